// File: rtl/covox_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package : covox_pkg                                                   |
// | Shared defaults and helpers for the covox sigma-delta DAC:            |
// |   BEEP_LEVEL_DEF  - mix contribution of a high beeper level           |
// |   TAPE_LEVEL_DEF  - mix contribution of a high tape-out level         |
// |   SYNC_STAGES_DEF - flop depth of each input synchronizer (2..3)      |
// |   MIX_W           - width of the unsaturated mix sum                  |
// |   sat_mix()       - clamp a MIX_W-bit sum to one byte                 |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
package covox_pkg;

  localparam logic [7:0] BEEP_LEVEL_DEF  = 8'd64;
  localparam logic [7:0] TAPE_LEVEL_DEF  = 8'd16;
  localparam int         SYNC_STAGES_DEF = 2;
  localparam int         MIX_W           = 10;

  // Any bit set above bit 7 means the sum exceeded 255.
  function automatic logic [7:0] sat_mix(input logic [MIX_W-1:0] sum);
    return (|sum[MIX_W-1:8]) ? 8'hFF : sum[7:0];
  endfunction

endpackage : covox_pkg
`default_nettype wire

// File: rtl/covox_sd_dac_sd_mod1.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : sd_mod1                                                      |
// | First-order sigma-delta modulator. The 8-bit accumulator wraps freely;|
// | the carry out of each addition is the output bit, so over 256 cycles  |
// | of constant input M the output is high exactly M times.               |
// | Ports:                                                                |
// |   cpu_clock  in   clock, rising edge                                  |
// |   reset      in   asynchronous, active-low                            |
// |   mix_q      in   8-bit level to modulate                             |
// |   dac_out    out  registered carry bitstream                          |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module sd_mod1 (
  input  logic       cpu_clock,
  input  logic       reset,
  input  logic [7:0] mix_q,
  output logic       dac_out
);

  logic [7:0] acc;
  logic [8:0] acc_sum;

  always_comb begin
    acc_sum = {1'b0, acc} + {1'b0, mix_q};
  end

  // The accumulator is never cleared or saturated in operation: its
  // wrap-around is what produces the carry pattern.
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      acc     <= 8'h00;
      dac_out <= 1'b0;
    end else begin
      acc     <= acc_sum[7:0];
      dac_out <= acc_sum[8];
    end
  end

endmodule : sd_mod1
`default_nettype wire

// File: rtl/covox_sd_dac.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : covox_sd_dac                                                 |
// | Covox-style 8-bit DAC for a Z80 system. Port writes are captured on   |
// | the synchronized rising edge of the covox select, mixed with beeper   |
// | and tape-out levels, saturated, registered and fed to a first-order   |
// | sigma-delta modulator.                                                |
// | Ports:                                                                |
// |   cpu_clock  in   sole clock, rising edge                             |
// |   reset      in   asynchronous, active-low                            |
// |   covox      in   port-write select (asynchronous to cpu_clock)       |
// |   d          in   data bus, stable while covox is high                |
// |   beeper     in   beeper level                                        |
// |   tapeout    in   tape-out level                                      |
// |   dac_out    out  sigma-delta bitstream for an external RC filter     |
// |   sample     out  currently latched covox byte                        |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module covox_sd_dac
  import covox_pkg::*;
#(
  parameter logic [7:0] BEEP_LEVEL  = BEEP_LEVEL_DEF,
  parameter logic [7:0] TAPE_LEVEL  = TAPE_LEVEL_DEF,
  parameter int         SYNC_STAGES = SYNC_STAGES_DEF   // legal 2..3
) (
  input  logic       cpu_clock,
  input  logic       reset,
  input  logic       covox,
  input  logic [7:0] d,
  input  logic       beeper,
  input  logic       tapeout,
  output logic       dac_out,
  output logic [7:0] sample
);

  localparam int PAD_W = MIX_W - 8;

  // Synchronizer chains; bit 0 is the first stage, bit SYNC_STAGES-1 the last.
  logic [SYNC_STAGES-1:0] covox_sync;
  logic [SYNC_STAGES-1:0] beep_sync;
  logic [SYNC_STAGES-1:0] tape_sync;

  logic             covox_s;
  logic             covox_prev;
  logic             beep_s;
  logic             tape_s;
  logic             capture;
  logic [MIX_W-1:0] mix_sum;
  logic [7:0]       mix_q;

  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      covox_sync <= '0;
      beep_sync  <= '0;
      tape_sync  <= '0;
    end else begin
      covox_sync <= {covox_sync[SYNC_STAGES-2:0], covox};
      beep_sync  <= {beep_sync[SYNC_STAGES-2:0], beeper};
      tape_sync  <= {tape_sync[SYNC_STAGES-2:0], tapeout};
    end
  end

  assign covox_s = covox_sync[SYNC_STAGES-1];
  assign beep_s  = beep_sync[SYNC_STAGES-1];
  assign tape_s  = tape_sync[SYNC_STAGES-1];

  // Edge detect: a held-high select captures once. Since the chains reset
  // to 0, a select already high at reset release also shows as an edge.
  // d is not synchronized: it is stable for the whole time covox is high,
  // which covers the capture edge.
  assign capture = covox_s & ~covox_prev;

  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      covox_prev <= 1'b0;
      sample     <= 8'h00;
    end else begin
      covox_prev <= covox_s;
      if (capture) begin
        sample <= d;
      end
    end
  end

  // Mix from the registered sample and the synchronized levels. A capture
  // and a level change on the same edge both land in the next mix_q.
  always_comb begin
    mix_sum = {{PAD_W{1'b0}}, sample};
    if (beep_s) begin
      mix_sum = mix_sum + {{PAD_W{1'b0}}, BEEP_LEVEL};
    end
    if (tape_s) begin
      mix_sum = mix_sum + {{PAD_W{1'b0}}, TAPE_LEVEL};
    end
  end

  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      mix_q <= 8'h00;
    end else begin
      mix_q <= sat_mix(mix_sum);
    end
  end

  sd_mod1 u_mod (
    .cpu_clock (cpu_clock),
    .reset     (reset),
    .mix_q     (mix_q),
    .dac_out   (dac_out)
  );

endmodule : covox_sd_dac
`default_nettype wire
